regfile_wb: RTL

- General-purpose register file for the five-stage core.
- Write side is the consumer end of the write-back interface: it commits the destination address, write enable and result data emitted by the MEM/WB pipeline register.
- Read side serves the ID stage through two operand read ports. A third read port serves debug.
- Same-cycle write-to-read bypass removes the WB→ID hazard. A commit counter supports performance monitoring.

---
 rtl/regfile_wb.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_wb.sv
// General-purpose register file for the five-stage core.
// Write side commits the MEM/WB result; two bypassed operand read ports
// serve ID, a third unbypassed port exposes committed state for debug.
module regfile_wb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  commit_cnt
);

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              commit;

    // A commit needs wb_wreg first, so wb_wd/wb_wdata are ignored when it is low.
    assign commit = wb_wreg && (wb_wd != '0);
    assign cnt_d  = cnt_q + CNT_W'(1);

    // Register array: flops so that every entry clears asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[wb_wd] <= wb_wdata;
        end
    end

    // Commit counter, wraps modulo 2**CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (commit) begin
            cnt_q <= cnt_d;
        end
    end

    assign commit_cnt = cnt_q;

    // Operand port 1: reset, enable, r0, then same-cycle write bypass.
    always_comb begin
        rdata1 = '0;
        if (rst && re1 && (raddr1 != '0)) begin
            if (wb_wreg && (raddr1 == wb_wd)) begin
                rdata1 = wb_wdata;
            end else begin
                rdata1 = regs_q[raddr1];
            end
        end
    end

    // Operand port 2: same priority as port 1.
    always_comb begin
        rdata2 = '0;
        if (rst && re2 && (raddr2 != '0)) begin
            if (wb_wreg && (raddr2 == wb_wd)) begin
                rdata2 = wb_wdata;
            end else begin
                rdata2 = regs_q[raddr2];
            end
        end
    end

    // Debug port: committed state only, never bypassed.
    always_comb begin
        dbg_data = '0;
        if (rst && (dbg_addr != '0)) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

endmodule
